// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline-control types and helpers.
package cpu_types_pkg;
   typedef enum logic [1:0] {RUN, DSTALL, HALTED} ctrl_state_t;
   typedef logic [4:0] regbits_t;
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
      return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
   endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard between the ID/EX load and the IF/ID sources.
module hazard_detect
   import cpu_types_pkg::*;
(
   input  logic     ex_dren_i,
   input  regbits_t ex_wsel_i,
   input  regbits_t id_rs_i,
   input  regbits_t id_rt_i,
   input  logic     id_uses_rt_i,
   output logic     lu_hz_o
);
   // r0 is hardwired to zero, so a load targeting it never creates a dependency
   assign lu_hz_o = ex_dren_i && ex_wsel_i != '0 &&
                    (ex_wsel_i == id_rs_i || (id_uses_rt_i && ex_wsel_i == id_rt_i));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stage enable/flush sequencer and halt state for the five-stage pipeline.
// Optional PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module pipeline_ctrl
   import cpu_types_pkg::*;
(
   input  logic     CLK,
   input  logic     RST,
   input  logic     ihit,
   input  logic     dhit,
   input  logic     mem_dREN,
   input  logic     mem_dWEN,
   input  logic     mem_halt,
   input  logic     ex_dREN,
   input  regbits_t ex_wsel,
   input  regbits_t id_rs,
   input  regbits_t id_rt,
   input  logic     id_uses_rt,
   input  logic     ex_branch_taken,
   output logic     pc_en,
   output logic     fd_en,
   output logic     dx_en,
   output logic     xm_en,
   output logic     mw_en,
   output logic     fd_flush,
   output logic     dx_flush,
   output logic     xm_flush,
   output logic     mw_flush,
   output logic     dstall,
   output logic     halt
`ifdef PERF_CNT_EN
   ,output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);
   ctrl_state_t state_q, state_d;
   logic        lu_hz, dmiss, live;

   hazard_detect u_hazard_detect (
      .ex_dren_i   (ex_dREN),
      .ex_wsel_i   (ex_wsel),
      .id_rs_i     (id_rs),
      .id_rt_i     (id_rt),
      .id_uses_rt_i(id_uses_rt),
      .lu_hz_o     (lu_hz)
   );

   assign dmiss = (mem_dREN || mem_dWEN) && !dhit;
   assign live  = state_q != HALTED;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= RUN;
      else     state_q <= state_d;
   end

   // RUN and DSTALL share exits: a miss (re)enters DSTALL, a clean halt goes to HALTED
   always_comb begin
      state_d = state_q;
      if (live) state_d = dmiss ? DSTALL : mem_halt ? HALTED : RUN;
   end

   always_comb begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      dx_en    = 1'b0;
      xm_en    = 1'b0;
      mw_en    = 1'b0;
      fd_flush = 1'b0;
      dx_flush = 1'b0;
      if (live && !dmiss) begin
         xm_en = 1'b1;
         mw_en = 1'b1;
         if (ex_branch_taken) begin
            pc_en    = 1'b1;
            fd_flush = 1'b1;
            dx_flush = 1'b1;
         end else if (lu_hz) begin
            dx_flush = 1'b1;
         end else if (!ihit) begin
            fd_flush = 1'b1;
            dx_en    = 1'b1;
         end else begin
            pc_en = 1'b1;
            fd_en = 1'b1;
            dx_en = 1'b1;
         end
      end
   end

   assign xm_flush = 1'b0;
   assign mw_flush = 1'b0;
   assign dstall   = state_q == DSTALL;
   assign halt     = state_q == HALTED;

`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   always_comb begin
      stall_cnt_d = sat_inc(stall_cnt_q, live && (dmiss || (lu_hz && !ex_branch_taken) || !ihit));
      flush_cnt_d = sat_inc(flush_cnt_q, live && !dmiss && ex_branch_taken);
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed plus random checks of pipeline_ctrl against a rule-level model.
module tb_pipeline_ctrl;
   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       ihit = 1'b1, dhit = 1'b0, mem_dREN = 1'b0, mem_dWEN = 1'b0, mem_halt = 1'b0;
   logic       ex_dREN = 1'b0, id_uses_rt = 1'b0, ex_branch_taken = 1'b0;
   logic [4:0] ex_wsel = '0, id_rs = '0, id_rt = '0;
   logic       pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, mw_flush, dstall, halt;
`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int failures = 0;
   bit m_halted = 1'b0;
   bit m_miss = 1'b0;
   int unsigned m_stall = 0;
   int unsigned m_flush = 0;

   pipeline_ctrl dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
      .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
      .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
      .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush), .mw_flush(mw_flush),
      .dstall(dstall), .halt(halt)
`ifdef PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic bit load_use();
      return ex_dREN && ex_wsel != 0 && (ex_wsel == id_rs || (id_uses_rt && ex_wsel == id_rt));
   endfunction

   function automatic bit data_miss();
      return (mem_dREN || mem_dWEN) && !dhit;
   endfunction

   // {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, mw_flush}
   function automatic logic [8:0] expected_ctrl();
      if (m_halted || data_miss()) return 9'b0_0000_0000;
      if (ex_branch_taken)         return 9'b1_0011_1100;
      if (load_use())              return 9'b0_0011_0100;
      if (!ihit)                   return 9'b0_0111_1000;
      return 9'b1_1111_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check(input string tag);
      chk(tag, 64'({halt, dstall, pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, mw_flush}),
          64'({m_halted, m_miss, expected_ctrl()}));
`ifdef PERF_CNT_EN
      chk({tag, "_cnt"}, {stall_cnt, flush_cnt}, {m_stall, m_flush});
`endif
   endtask

   task automatic drive(input logic ih, dh, mr, mw, mh, exr, input logic [4:0] ws, rs, rt,
                        input logic urt, br);
      ihit = ih; dhit = dh; mem_dREN = mr; mem_dWEN = mw; mem_halt = mh;
      ex_dREN = exr; ex_wsel = ws; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_branch_taken = br;
   endtask

   // Apply inputs, check mid-cycle, then advance the model across the edge.
   task automatic step(input string tag, input logic ih, dh, mr, mw, mh, exr,
                       input logic [4:0] ws, rs, rt, input logic urt, br);
      bit miss, lu;
      drive(ih, dh, mr, mw, mh, exr, ws, rs, rt, urt, br);
      #4;
      check(tag);
      miss = data_miss();
      lu = load_use();
      @(posedge CLK);
      if (!m_halted) begin
         if (miss || (lu && !br) || !ih) m_stall++;
         if (!miss && br) m_flush++;
         m_miss = miss;
         m_halted = !miss && mh;
      end
      #1;
   endtask

   task automatic idle(input string tag);
      step(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic reset_dut();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      RST = 1'b1;
      m_halted = 0; m_miss = 0; m_stall = 0; m_flush = 0;
      repeat (3) begin
         @(posedge CLK);
         #1;
         check("reset");
      end
      RST = 1'b0;
   endtask

   initial begin
      reset_dut();
      idle("run_normal");

      // data miss for 4 cycles then hit
      repeat (4) step("dmiss_freeze", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("dmiss_release", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("after_dmiss");
      step("store_miss", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step("store_hit", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

      // load-use: one bubble, then normal; r0 destination never stalls
      step("lu_hz", 1, 0, 0, 0, 0, 1, 5, 5, 0, 0, 0);
      idle("lu_next");
      step("lu_rt", 1, 0, 0, 0, 0, 1, 7, 1, 7, 1, 0);
      step("lu_rt_unused", 1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0);
      step("lu_r0", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      step("imiss", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // branch wins over load-use and imiss
      step("branch_over_hz", 0, 0, 0, 0, 0, 1, 5, 5, 0, 0, 1);

      // branch held pending during a miss, applied on the hit cycle
      repeat (2) step("branch_in_miss", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      step("branch_on_dhit", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle("after_branch");

      // reset in the middle of a stall clears DSTALL immediately
      step("pre_rst_miss", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("in_dstall");
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      RST = 1'b1;
      m_halted = 0; m_miss = 0; m_stall = 0; m_flush = 0;
      #1;
      check("rst_mid_stall");
      #1;
      RST = 1'b0;
      idle("after_rst");

      // halt deferred by a miss, then taken once the access completes
      step("halt_in_miss", 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      step("halt_on_dhit", 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      repeat (4) step("halted_toggle", 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0, 0, 0, 1'($urandom));
      reset_dut();

      // random traffic without halts
      repeat (400) step("random", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 5) == 0), 0, 1'($urandom),
                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        1'($urandom), 1'($urandom_range(0, 4) == 0));

      // clean halt from RUN, then toggling has no effect
      step("halt_req", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      check("halted");
      repeat (4) step("halted_idle", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 1'($urandom), 5, 5, 5, 1, 1'($urandom));
      reset_dut();
      idle("post_halt_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Each cycle it decides whether each stage register advances, holds or takes a bubble. It does this from three inputs: the memory handshakes (`ihit`, `dhit`), load-use hazards between ID and EX, and taken branches resolved in EX. It also owns the processor halt state. It sits beside the datapath and drives the `EN`/`flush` pins of every pipe register.

## Interface
- No parameters.
- CLK  in  1  core clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- mem_dREN, mem_dWEN  in  1  EX/MEM stage holds a load / store
- mem_halt  in  1  EX/MEM stage holds a halt instruction
- ex_dREN  in  1  ID/EX stage holds a load
- ex_wsel  in  5  destination register of the ID/EX instruction
- id_rs, id_rt  in  5  source registers of the IF/ID instruction
- id_uses_rt  in  1  IF/ID instruction reads rt
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- pc_en  out  1  PC loads next value
- fd_en, dx_en, xm_en, mw_en  out  1  stage register advance enables
- fd_flush, dx_flush, xm_flush, mw_flush  out  1  load a bubble; overrides en inside the pipe
- dstall  out  1  high while in DSTALL
- halt  out  1  registered processor halt

## Operation
- FSM states (`ctrl_state_t`): RUN, DSTALL, HALTED. Reset state is RUN.
- `dmiss = (mem_dREN | mem_dWEN) & ~dhit`.
- `lu_hz = ex_dREN & (ex_wsel != 0) & (ex_wsel == id_rs | (id_uses_rt & ex_wsel == id_rt))`.
- Outputs are decoded from state and inputs. Priority is highest first:
  1. HALTED: all en = 0, all flush = 0, pc_en = 0.
  2. dmiss (any state except HALTED): freeze. All en = 0, pc_en = 0.
  3. ex_branch_taken: pc_en = 1, fd_flush = 1, dx_flush = 1, xm_en = mw_en = 1. A simultaneous `lu_hz` or `~ihit` is ignored, because the offending instructions are squashed.
  4. lu_hz: pc_en = 0, fd_en = 0, dx_flush = 1, xm_en = mw_en = 1.
  5. ~ihit: pc_en = 0, fd_flush = 1, dx_en = xm_en = mw_en = 1.
  6. Otherwise all en = 1, pc_en = 1.
- xm_flush and mw_flush are always 0. They exist for future exception handling.
- Transitions:
  - RUN -> DSTALL on dmiss.
  - DSTALL -> RUN on dhit. The advance on the dhit cycle follows rules 3-6.
  - RUN/DSTALL -> HALTED when `mem_halt & ~dmiss`. mw_en is 1 on that edge, so the halt reaches MEM/WB.
  - HALTED is left only by RST.
- `halt` is 1 exactly when the state is HALTED.

## Timing
- All outputs except `halt` and `dstall` are combinational, valid before the next rising CLK.
- `halt` and `dstall` are registered.
- Reset values: state RUN, halt 0, dstall 0, counters 0.
  - During RST with no misses (ihit = 1, mem accesses idle), decode gives all en = 1, pc_en = 1, flushes 0. The pipe registers themselves are also held in reset.
- RST asserted mid-stall drops DSTALL immediately. The next request is reissued by the datapath.
- A branch taken during a dmiss stays pending: EX is frozen, so `ex_branch_taken` is re-evaluated on the dhit cycle.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM and `ex_dREN` is 0.
- HALTED is reached 1 cycle after `mem_halt` when there is no dmiss.

## Configuration
- `PERF_CNT_EN` defined:
  - Adds outputs `stall_cnt[31:0]` and `flush_cnt[31:0]`, both saturating at 32'hFFFFFFFF.
  - `stall_cnt` increments on every non-HALTED cycle with dmiss, lu_hz (not overridden by a branch) or ~ihit.
  - `flush_cnt` increments on each taken-branch flush.
- Undefined: the ports and counters are absent. Control behaviour is identical either way.

## Structure
- `cpu_types_pkg` holds the `ctrl_state_t` enum and the `regbits_t` 5-bit register type.
- Sub-module `hazard_detect` computes `lu_hz`. It is combinational and is reused by the forwarding unit later.

## Test plan
- Reset held 3 cycles with ihit=1 -> halt=0, dstall=0, all en=1, counters 0.
- mem_dREN=1, dhit=0 for 4 cycles, then dhit=1 -> all en=0 and dstall=1 for cycles 2-4. On the dhit cycle all en=1 and the state returns to RUN. stall_cnt=4.
- ex_dREN=1, ex_wsel=5, id_rs=5 -> one cycle of pc_en=0, fd_en=0, dx_flush=1. The next cycle is normal. Repeat with ex_wsel=0 -> no stall.
- ex_branch_taken=1 with lu_hz=1 and ihit=0 -> pc_en=1, fd_flush=dx_flush=1, flush_cnt += 1.
- ex_branch_taken=1 during dmiss for 2 cycles -> frozen. On the dhit cycle the branch flush is applied.
- mem_halt=1 with no access -> halt=1 next cycle. All en stay 0 until RST, and later ihit/dhit toggling has no effect.
